// File: rtl/barrel_shifter.sv
// Registered log2 barrel shifter: logical left shift, arithmetic right shift,
// one-cycle latency, one result per cycle with no stall and no backpressure.
// Optional feature: define BS_ROTATE_EN to add the bs_rot input, which turns
// either shift direction into a rotate. The default build (macro undefined)
// has no bs_rot port and no rotate logic.
module barrel_shifter #(
  parameter int IWIDTH = 4,
  parameter int SWIDTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              bs_dir,
  input  logic [SWIDTH-1:0] bs_amt,
  input  logic [IWIDTH-1:0] d_in,
`ifdef BS_ROTATE_EN
  input  logic              bs_rot,
`endif
  output logic              out_valid,
  output logic [IWIDTH-1:0] d_out
);

  // stage_data[k] is the input of mux stage k; stage_data[SWIDTH] is the result
  logic [IWIDTH-1:0] stage_data [0:SWIDTH];

  assign stage_data[0] = d_in;

  genvar k;
  generate
    for (k = 0; k < SWIDTH; k++) begin : g_stage
      // Each stage moves its input by a fixed 2^k positions when bs_amt[k] is set.
      // SWIDTH = clog2(IWIDTH), so every stage distance is smaller than IWIDTH
      // and all part-selects below stay in range.
      localparam int SH = 1 << k;

      logic [IWIDTH-1:0] shl;
      logic [IWIDTH-1:0] shr;

      // Bits that fall off the far end of this stage: either re-enter (rotate)
      // or are replaced by zero (left) / the sign bit (right).
      // The sign bit survives every arithmetic right stage unchanged, so the
      // stage input MSB is always the original operand MSB.
`ifdef BS_ROTATE_EN
      always_comb begin
        shl = {stage_data[k][IWIDTH-1-SH:0], {SH{1'b0}}};
        shr = {{SH{stage_data[k][IWIDTH-1]}}, stage_data[k][IWIDTH-1:SH]};
        if (bs_rot) begin
          shl = {stage_data[k][IWIDTH-1-SH:0], stage_data[k][IWIDTH-1:IWIDTH-SH]};
          shr = {stage_data[k][SH-1:0], stage_data[k][IWIDTH-1:SH]};
        end
      end
`else
      always_comb begin
        shl = {stage_data[k][IWIDTH-1-SH:0], {SH{1'b0}}};
        shr = {{SH{stage_data[k][IWIDTH-1]}}, stage_data[k][IWIDTH-1:SH]};
      end
`endif

      // Stage mux: pass through, or take the shifted value in the chosen direction
      always_comb begin
        stage_data[k+1] = stage_data[k];
        if (bs_amt[k]) begin
          stage_data[k+1] = bs_dir ? shr : shl;
        end
      end
    end
  endgenerate

  // Output register: capture a result only on a request. The valid strobe
  // follows the request by exactly one cycle. Reset clears both outputs
  // and discards any result that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        d_out <= stage_data[SWIDTH];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter (IWIDTH=4). Directed vectors plus
// randomized traffic checked against a bit-level reference model.
// Build with BS_ROTATE_EN defined to also exercise the rotate input.
module tb_barrel_shifter;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         bs_dir;
  logic [S-1:0] bs_amt;
  logic [W-1:0] d_in;
  logic         rot_mode;
  logic         out_valid;
  logic [W-1:0] d_out;

  int errors;
  int checks;

  barrel_shifter #(.IWIDTH(W), .SWIDTH(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .bs_dir    (bs_dir),
    .bs_amt    (bs_amt),
    .d_in      (d_in),
`ifdef BS_ROTATE_EN
    .bs_rot    (rot_mode),
`endif
    .out_valid (out_valid),
    .d_out     (d_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each result bit is picked from the operand position the shift
  // describes; positions off the end give 0 (left), sign (right) or wrap (rotate).
  function automatic logic [W-1:0] ref_result(input logic dir, input logic rot,
                                              input int amt, input logic [W-1:0] d);
    logic [W-1:0] res;
    int src;
    res = '0;
    for (int i = 0; i < W; i++) begin
      if (!dir) begin
        src = i - amt;
        if (src >= 0) res[i] = d[src];
        else          res[i] = rot ? d[src + W] : 1'b0;
      end else begin
        src = i + amt;
        if (src < W) res[i] = d[src];
        else         res[i] = rot ? d[src - W] : d[W-1];
      end
    end
    return res;
  endfunction

  // Drive one cycle of inputs at the falling edge, return 1 ns after the rising edge
  task automatic send(input logic v, input logic dir, input logic [S-1:0] amt,
                      input logic [W-1:0] d);
    @(negedge clk);
    in_valid = v;
    bs_dir   = dir;
    bs_amt   = amt;
    d_in     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b1; bs_dir = 1'b0; bs_amt = '0; d_in = 4'b1111; rot_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (d_out !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: d_out=%b out_valid=%b, want 0000/0", d_out, out_valid);
    end
    // release away from the edge; the very next rising edge takes a request
    @(negedge clk);
    rst_n = 1'b1;
    bs_amt = 2'd1; d_in = 4'b0101;
    @(posedge clk);
    #1;
    checks++;
    if (d_out !== 4'b1010 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL first_request: d_out=%b out_valid=%b, want 1010/1", d_out, out_valid);
    end
    send(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_left_vectors;
    logic [S-1:0] amts [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [W-1:0] exp  [4] = '{4'b1000, 4'b1110, 4'b1100, 4'b1111};
    rot_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b0, amts[i], 4'b1111);
      checks++;
      if (d_out !== exp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL left_1111_amt%0d: d_out=%b out_valid=%b, want %b/1",
                 amts[i], d_out, out_valid, exp[i]);
      end
    end
    send(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_right_vectors;
    logic [S-1:0] amts [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [W-1:0] exp1 [4] = '{4'b1111, 4'b1101, 4'b1110, 4'b1011};
    logic [W-1:0] exp0 [4] = '{4'b0000, 4'b0001, 4'b0000, 4'b0010};
    rot_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1, amts[i], 4'b1011);
      checks++;
      if (d_out !== exp1[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL right_1011_amt%0d: d_out=%b out_valid=%b, want %b/1",
                 amts[i], d_out, out_valid, exp1[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 1'b1, amts[i], 4'b0010);
      checks++;
      if (d_out !== exp0[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL right_0010_amt%0d: d_out=%b out_valid=%b, want %b/1",
                 amts[i], d_out, out_valid, exp0[i]);
      end
    end
    send(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_hold_random;
    logic [W-1:0] held;
    logic         v, dir;
    logic [S-1:0] amt;
    logic [W-1:0] d;
    held = d_out;
    rot_mode = 1'b0;
    for (int i = 0; i < 60; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      dir = 1'($urandom_range(0, 1));
      amt = S'($urandom_range(0, W-1));
      d   = W'($urandom);
`ifdef BS_ROTATE_EN
      rot_mode = 1'($urandom_range(0, 1));
`endif
      if (v) held = ref_result(dir, rot_mode, int'(amt), d);
      send(v, dir, amt, d);
      checks++;
      if (d_out !== held || out_valid !== v) begin
        errors++;
        $display("[TB] FAIL random_%0d (v=%b dir=%b rot=%b amt=%0d d=%b): d_out=%b out_valid=%b, want %b/%b",
                 i, v, dir, rot_mode, amt, d, d_out, out_valid, held, v);
      end
    end
    rot_mode = 1'b0;
    send(1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back;
    logic         dirs [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [S-1:0] amts [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
    logic [W-1:0] ds   [4] = '{4'b0011, 4'b1000, 4'b0110, 4'b0110};
    logic [W-1:0] exp  [4] = '{4'b0110, 4'b1110, 4'b0000, 4'b0011};
    rot_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, dirs[i], amts[i], ds[i]);
      checks++;
      if (d_out !== exp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL back_to_back_%0d: d_out=%b out_valid=%b, want %b/1",
                 i, d_out, out_valid, exp[i]);
      end
    end
    send(1'b0, 1'b1, 2'd3, 4'b1111);
    checks++;
    if (d_out !== 4'b0011 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL back_to_back_hold: d_out=%b out_valid=%b, want 0011/0", d_out, out_valid);
    end
  endtask

  task automatic test_reset_midstream;
    rot_mode = 1'b0;
    send(1'b1, 1'b0, 2'd0, 4'b1001);
    // keep requesting, then pull reset low between edges
    @(negedge clk);
    in_valid = 1'b1; bs_dir = 1'b1; bs_amt = 2'd1; d_in = 4'b1100;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_out !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_immediate: d_out=%b out_valid=%b, want 0000/0", d_out, out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (d_out !== 4'b0000 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_held: d_out=%b out_valid=%b, want 0000/0", d_out, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (d_out !== 4'b0000 || out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_release_%0d: d_out=%b out_valid=%b, want 0000/0", i, d_out, out_valid);
      end
    end
  endtask

`ifdef BS_ROTATE_EN
  task automatic test_rotate;
    rot_mode = 1'b1;
    send(1'b1, 1'b1, 2'd1, 4'b1011);
    checks++;
    if (d_out !== 4'b1101 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rotate_right: d_out=%b out_valid=%b, want 1101/1", d_out, out_valid);
    end
    send(1'b1, 1'b0, 2'd1, 4'b1011);
    checks++;
    if (d_out !== 4'b0111 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rotate_left: d_out=%b out_valid=%b, want 0111/1", d_out, out_valid);
    end
    rot_mode = 1'b0;
    send(1'b0, 1'b0, '0, '0);
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_left_vectors();
    test_right_vectors();
    test_back_to_back();
`ifdef BS_ROTATE_EN
    test_rotate();
`endif
    test_hold_random();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
